clock_phase_scheduler: RTL and testbench
========================================

// Module: clock_phase_scheduler
// PURPOSE
//  Frame-based phase scheduler that sequences the processor, imem, dmem and regfile clock-enable strobes from one
//  system clock. A FRAME_LEN-tick frame counter runs while enabled. Each channel is high for a programmable window
//  (offset, width) inside the frame. Window config is double-buffered and commits only at frame boundaries, so phases
//  never glitch mid-frame. Start/stop control sits between the top-level reset/boot logic and the memory/regfile enables.
// PARAMETERS
//  NCH       4  number of phase channels (0=processor,1=imem,2=dmem,3=regfile)
//  CW        4  width of frame counter, offset and width fields
//  FRAME_LEN 6  ticks per frame, 2..2**CW-1
//  DEF_OFF   0  reset offset of every channel
//  DEF_WID   3  reset width of every channel
// PORTS
//  clock        in   1       system clock, all state on rising edge
//  reset        in   1       asynchronous, active-low reset
//  start        in   1       level/pulse: begin running frames
//  stop         in   1       level/pulse: finish current frame, then idle
//  cfg_we       in   1       write shadow window of channel cfg_ch
//  cfg_ch       in   2       channel index (writes with cfg_ch>=NCH ignored)
//  cfg_off      in   CW      window start tick
//  cfg_wid      in   CW      window length in ticks (0 = channel never high)
//  ch_out       out  NCH     registered phase enables
//  frame_start  out  1       high on tick 0 of every running frame
//  busy         out  1       state != IDLE
//  cfg_pending  out  1       a shadow write awaits commit
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE, cnt=0, ch_out=0, frame_start=0, busy=0, cfg_pending=0.
//    Active and shadow windows = (DEF_OFF, DEF_WID).
//  States: IDLE, RUN, DRAIN.
//  IDLE: cnt held 0, ch_out=0.
//    start & !stop -> RUN. The next cycle is tick 0.
//    start & stop together -> stay IDLE.
//  RUN: cnt increments, wraps FRAME_LEN-1 -> 0.
//    stop -> DRAIN. start is ignored.
//  DRAIN: cnt keeps counting.
//    start & !stop -> RUN with no frame restart.
//    At the wrap cycle (cnt==FRAME_LEN-1) -> IDLE; tick 0 is not issued.
//  Outputs are registered and describe the current cnt, with zero latency vs cnt.
//    ch_out[i] = busy && off_i <= cnt < off_i+wid_i. The sum is computed CW+1 bits wide, with no wrap: windows past
//    FRAME_LEN are clipped. off_i >= FRAME_LEN -> never high.
//  frame_start = busy && cnt==0.
//  Config: cfg_we writes shadow[cfg_ch] and sets cfg_pending. Later writes to the same channel overwrite it.
//  Commit copies all shadows to active, clears cfg_pending, and takes effect on the first tick of the new frame.
//    Commit happens on the RUN wrap edge (cnt FRAME_LEN-1 -> 0), or on the cycle after the write while IDLE/DRAIN->IDLE.
//  A write in the same cycle as a commit lands in shadow only: it is excluded from that commit and cfg_pending stays 1.
//  Reset asserted mid-frame: all outputs drop to 0 immediately (async). Pending shadows are discarded.
// CONFIGURATION
//  CLKSCHED_STEP_EN defined:
//    Adds input `step` (1 bit) and state STEP.
//    IDLE & step & !start -> STEP: runs exactly one frame (ticks 0..FRAME_LEN-1), then IDLE.
//    start/stop are ignored in STEP. busy=1 in STEP.
//    A commit happens at entry to STEP if pending.
//  Undefined: no `step` port, no STEP state. Only start/stop control the scheduler.
// TESTING (FRAME_LEN=6, NCH=4)
//  1. Reset with defaults, pulse start -> ch_out=4'b1111 on ticks 0..2 and 0 on ticks 3..5; frame_start every 6 cycles;
//     busy=1.
//  2. Mid-frame at tick 2, write ch2 off=4 wid=2 -> cfg_pending=1. ch2 is unchanged for the rest of the frame.
//     Next frame ch2 is high only on ticks 4,5, and cfg_pending=0.
//  3. Pulse stop at tick 1 -> ticks 2..5 complete normally, then busy=0 and ch_out=0; no further frame_start.
//     Repeat with start asserted at tick 3 of DRAIN -> running continues without restart.
//  4. Edge windows: ch1 off=5 wid=4 -> high only on tick 5. ch3 wid=0 -> never high. ch0 off=7 -> never high.
//     A cfg write with cfg_ch=3 on the wrap cycle -> applied one frame later.
//  5. start&stop in the same IDLE cycle -> stays IDLE.
//     Assert reset at tick 3 -> all outputs 0 asynchronously; after release, active windows = defaults.
//  6. (CLKSCHED_STEP_EN) Pulse step in IDLE -> exactly 6 busy cycles with one frame_start, then IDLE.
//     start during STEP is ignored.

Source files
------------

// File: rtl/clock_phase_scheduler_if.sv
// ----------------------------------------------------------------------------
// clock_phase_scheduler_if
//   Control, configuration and status bundle of the clock phase scheduler.
//
//   Control   : start, stop (and step when CLKSCHED_STEP_EN is defined)
//   Config    : cfg_we, cfg_ch, cfg_off, cfg_wid  -- shadow window write port
//   Status    : ch_out, frame_start, busy, cfg_pending
//
//   Modports:
//     master : the boot/reset controller that drives control and config
//     slave  : the scheduler itself
//
//   Optional feature macro: CLKSCHED_STEP_EN (adds the single-frame step input)
// ----------------------------------------------------------------------------
interface clock_phase_scheduler_if #(
    parameter int NCH = 4,
    parameter int CW  = 4
);
    logic           start;
    logic           stop;
    logic           cfg_we;
    logic [1:0]     cfg_ch;
    logic [CW-1:0]  cfg_off;
    logic [CW-1:0]  cfg_wid;
    logic [NCH-1:0] ch_out;
    logic           frame_start;
    logic           busy;
    logic           cfg_pending;
`ifdef CLKSCHED_STEP_EN
    logic           step;

    modport master (
        output start, stop, step, cfg_we, cfg_ch, cfg_off, cfg_wid,
        input  ch_out, frame_start, busy, cfg_pending
    );
    modport slave (
        input  start, stop, step, cfg_we, cfg_ch, cfg_off, cfg_wid,
        output ch_out, frame_start, busy, cfg_pending
    );
`else
    modport master (
        output start, stop, cfg_we, cfg_ch, cfg_off, cfg_wid,
        input  ch_out, frame_start, busy, cfg_pending
    );
    modport slave (
        input  start, stop, cfg_we, cfg_ch, cfg_off, cfg_wid,
        output ch_out, frame_start, busy, cfg_pending
    );
`endif
endinterface

// File: rtl/clock_phase_scheduler.sv
// ----------------------------------------------------------------------------
// clock_phase_scheduler
//   Frame-based phase scheduler producing the processor / imem / dmem /
//   regfile clock-enable strobes. A FRAME_LEN-tick counter runs while the
//   scheduler is busy; each channel is high inside its (offset, width) window.
//   Window settings are written into shadow registers and copied to the
//   active set only at frame boundaries, so a phase never changes mid-frame.
//
//   Ports:
//     clock : system clock, all state on the rising edge
//     reset : asynchronous, active-low reset
//     bus   : clock_phase_scheduler_if.slave
//             start/stop control, shadow config write port,
//             registered ch_out / frame_start / busy / cfg_pending
//
//   Optional feature macro: CLKSCHED_STEP_EN
//     Adds bus.step and a STEP state that runs exactly one frame from IDLE.
// ----------------------------------------------------------------------------
module clock_phase_scheduler #(
    parameter int NCH       = 4,
    parameter int CW        = 4,
    parameter int FRAME_LEN = 6,
    parameter int DEF_OFF   = 0,
    parameter int DEF_WID   = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    clock_phase_scheduler_if.slave bus
);

`ifdef CLKSCHED_STEP_EN
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, STEP} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
`endif

    localparam logic [CW-1:0] LAST  = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] R_OFF = CW'(DEF_OFF);
    localparam logic [CW-1:0] R_WID = CW'(DEF_WID);

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [CW-1:0]  act_off [NCH];
    logic [CW-1:0]  act_wid [NCH];
    logic [CW-1:0]  sh_off  [NCH];
    logic [CW-1:0]  sh_wid  [NCH];
    logic [CW-1:0]  act_off_nxt [NCH];
    logic [CW-1:0]  act_wid_nxt [NCH];
    logic [CW-1:0]  sh_off_nxt  [NCH];
    logic [CW-1:0]  sh_wid_nxt  [NCH];
    logic           pending, pending_nxt;
    logic [NCH-1:0] ch_q, ch_nxt;
    logic           fs_q, fs_nxt;
    logic           busy_q, busy_nxt;
    logic           wrap, commit, cfg_hit;

    // Everything is computed for the cycle after the edge and then registered,
    // so the outputs line up with the registered counter without extra latency.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_nxt   = state;
        wrap        = (cnt == LAST);
        act_off_nxt = act_off;
        act_wid_nxt = act_wid;
        sh_off_nxt  = sh_off;
        sh_wid_nxt  = sh_wid;
        ch_nxt      = '0;

        unique case (state)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_nxt = RUN;
`ifdef CLKSCHED_STEP_EN
                end else if (bus.step && !bus.start) begin
                    state_nxt = STEP;
`endif
                end
            end
            RUN: begin
                if (bus.stop) state_nxt = DRAIN;
            end
            DRAIN: begin
                // A restart keeps counting, so the frame in flight is not restarted.
                if (bus.start && !bus.stop) state_nxt = RUN;
                else if (wrap)              state_nxt = IDLE;
            end
`ifdef CLKSCHED_STEP_EN
            STEP: begin
                if (wrap) state_nxt = IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
        // Leaving IDLE lands on tick 0; the counter only advances while busy.
        cnt_nxt  = (state == IDLE || state_nxt == IDLE || wrap) ? '0 : cnt + 1'b1;

        // Frame boundary: the wrap edge of any busy state, or any idle cycle.
        commit = pending && (state == IDLE || wrap);
        if (commit) begin
            act_off_nxt = sh_off;
            act_wid_nxt = sh_wid;
        end

        // The shadow write happens after the commit copy, so a same-cycle
        // write stays pending for the next boundary.
        cfg_hit = bus.cfg_we && (32'(bus.cfg_ch) < NCH);
        for (int i = 0; i < NCH; i++) begin
            if (bus.cfg_we && 32'(bus.cfg_ch) == i) begin
                sh_off_nxt[i] = bus.cfg_off;
                sh_wid_nxt[i] = bus.cfg_wid;
            end
        end
        pending_nxt = cfg_hit ? 1'b1 : (commit ? 1'b0 : pending);

        // Window end is formed one bit wider so off+wid never wraps around.
        for (int i = 0; i < NCH; i++) begin
            ch_nxt[i] = busy_nxt
                     && (act_off_nxt[i] <= cnt_nxt)
                     && ({1'b0, cnt_nxt} < ({1'b0, act_off_nxt[i]} + {1'b0, act_wid_nxt[i]}));
        end
        fs_nxt = busy_nxt && (cnt_nxt == '0);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            pending <= 1'b0;
            ch_q    <= '0;
            fs_q    <= 1'b0;
            busy_q  <= 1'b0;
            // NOTE: the window arrays are tiny register banks with a defined
            // power-up value, so they are reset like any other flop.
            for (int i = 0; i < NCH; i++) begin
                act_off[i] <= R_OFF;
                act_wid[i] <= R_WID;
                sh_off[i]  <= R_OFF;
                sh_wid[i]  <= R_WID;
            end
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pending <= pending_nxt;
            ch_q    <= ch_nxt;
            fs_q    <= fs_nxt;
            busy_q  <= busy_nxt;
            act_off <= act_off_nxt;
            act_wid <= act_wid_nxt;
            sh_off  <= sh_off_nxt;
            sh_wid  <= sh_wid_nxt;
        end
    end

    assign bus.ch_out      = ch_q;
    assign bus.frame_start = fs_q;
    assign bus.busy        = busy_q;
    assign bus.cfg_pending = pending;

endmodule

// File: tb/tb_clock_phase_scheduler.sv
// ----------------------------------------------------------------------------
// tb_clock_phase_scheduler
//   Directed bench for clock_phase_scheduler (NCH=4, CW=4, FRAME_LEN=6).
//   Expected {busy, frame_start, cfg_pending, ch_out} values are pushed to a
//   scoreboard queue before each clock edge and popped/compared one time unit
//   after it. The bench keeps its own copy of the active windows, updated by
//   the directed steps at the frame boundaries where a commit must occur.
// ----------------------------------------------------------------------------
module tb_clock_phase_scheduler;
    localparam int FL = 6;

    logic clock = 1'b0;
    logic reset;

    clock_phase_scheduler_if #(.NCH(4), .CW(4)) bus ();

    clock_phase_scheduler #(
        .NCH(4), .CW(4), .FRAME_LEN(FL), .DEF_OFF(0), .DEF_WID(3)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      tag;
        logic [6:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   n_fail  = 0;
    int   m_off [4];
    int   m_wid [4];

    task automatic set_defaults();
        for (int i = 0; i < 4; i++) begin
            m_off[i] = 0;
            m_wid[i] = 3;
        end
    endtask

    function automatic logic [3:0] win(int t);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[i] = (t >= m_off[i]) && (t < m_off[i] + m_wid[i]);
        return r;
    endfunction

    task automatic expect_out(string tag, logic [6:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic compare();
        exp_t       e;
        logic [6:0] obs;
        e   = sb.pop_front();
        obs = {bus.busy, bus.frame_start, bus.cfg_pending, bus.ch_out};
        n_total++;
        assert (obs === e.val) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: busy/fs/pend/ch observed=%b required=%b", e.tag, obs, e.val);
        end
    endtask

    // Apply whatever inputs the caller set, clock once, drop the pulses, check.
    task automatic tick(string tag, logic [6:0] v);
        expect_out(tag, v);
        @(posedge clock);
        #1;
        bus.start  = 1'b0;
        bus.stop   = 1'b0;
        bus.cfg_we = 1'b0;
`ifdef CLKSCHED_STEP_EN
        bus.step   = 1'b0;
`endif
        compare();
    endtask

    task automatic frame_tick(string tag, int t, bit pend);
        tick($sformatf("%s t%0d", tag, t), {1'b1, t == 0, pend, win(t)});
    endtask

    task automatic idle_tick(string tag);
        tick(tag, 7'b0);
    endtask

    task automatic cfg(int ch, int off, int wid);
        bus.cfg_we  = 1'b1;
        bus.cfg_ch  = 2'(ch);
        bus.cfg_off = 4'(off);
        bus.cfg_wid = 4'(wid);
    endtask

    initial begin
        reset       = 1'b0;
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.cfg_we  = 1'b0;
        bus.cfg_ch  = '0;
        bus.cfg_off = '0;
        bus.cfg_wid = '0;
`ifdef CLKSCHED_STEP_EN
        bus.step    = 1'b0;
`endif
        set_defaults();

        #12;
        expect_out("reset", 7'b0);
        compare();
        reset = 1'b1;
        idle_tick("idle after reset");

        // Defaults: all channels high on ticks 0..2, frame_start every 6 cycles.
        bus.start = 1'b1;
        for (int t = 0; t < FL; t++) frame_tick("defaults f1", t, 1'b0);
        for (int t = 0; t < 3; t++)  frame_tick("defaults f2", t, 1'b0);

        // Mid-frame shadow write at tick 2: old window until the boundary.
        cfg(2, 4, 2);
        for (int t = 3; t < FL; t++) frame_tick("ch2 pending", t, 1'b1);
        m_off[2] = 4; m_wid[2] = 2;
        for (int t = 0; t < FL; t++) frame_tick("ch2 committed", t, 1'b0);

        // Stop at tick 1: frame completes, then idle with no frame_start.
        frame_tick("stop", 0, 1'b0);
        frame_tick("stop", 1, 1'b0);
        bus.stop = 1'b1;
        for (int t = 2; t < FL; t++) frame_tick("drain", t, 1'b0);
        idle_tick("after drain a");
        idle_tick("after drain b");

        // Restart from DRAIN at tick 3 continues the frame without restart.
        bus.start = 1'b1;
        frame_tick("restart", 0, 1'b0);
        frame_tick("restart", 1, 1'b0);
        bus.stop = 1'b1;
        frame_tick("restart drain", 2, 1'b0);
        frame_tick("restart drain", 3, 1'b0);
        bus.start = 1'b1;
        frame_tick("resumed", 4, 1'b0);
        frame_tick("resumed", 5, 1'b0);
        frame_tick("resumed", 0, 1'b0);
        frame_tick("resumed", 1, 1'b0);

        // Edge windows: clipped, zero width, offset beyond the frame.
        cfg(1, 5, 4);
        frame_tick("edge cfg", 2, 1'b1);
        cfg(3, 0, 0);
        frame_tick("edge cfg", 3, 1'b1);
        cfg(0, 7, 3);
        frame_tick("edge cfg", 4, 1'b1);
        frame_tick("edge cfg", 5, 1'b1);
        m_off[1] = 5; m_wid[1] = 4;
        m_off[3] = 0; m_wid[3] = 0;
        m_off[0] = 7; m_wid[0] = 3;
        for (int t = 0; t < 3; t++) frame_tick("edge A", t, 1'b0);
        cfg(2, 0, 1);
        for (int t = 3; t < FL; t++) frame_tick("edge A", t, 1'b1);

        // Write to ch3 on the wrap cycle: ch2 commits now, ch3 one frame later.
        cfg(3, 2, 2);
        m_off[2] = 0; m_wid[2] = 1;
        for (int t = 0; t < FL; t++) frame_tick("wrap write B", t, 1'b1);
        m_off[3] = 2; m_wid[3] = 2;
        for (int t = 0; t < FL; t++) frame_tick("wrap write C", t, 1'b0);

        frame_tick("stop2", 0, 1'b0);
        bus.stop = 1'b1;
        for (int t = 1; t < FL; t++) frame_tick("drain2", t, 1'b0);
        idle_tick("after drain2");

        // start and stop together in IDLE: stay idle.
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        idle_tick("start&stop a");
        idle_tick("start&stop b");

        // Async reset at tick 3 with a pending shadow write.
        bus.start = 1'b1;
        for (int t = 0; t < 3; t++) frame_tick("pre reset", t, 1'b0);
        cfg(0, 1, 1);
        frame_tick("pre reset", 3, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        expect_out("async reset", 7'b0);
        compare();
        reset = 1'b1;
        set_defaults();
        idle_tick("idle after async reset");
        bus.start = 1'b1;
        for (int t = 0; t < FL; t++) frame_tick("defaults restored", t, 1'b0);
        bus.stop = 1'b1;
        frame_tick("stop3", 0, 1'b0);
        for (int t = 1; t < FL; t++) frame_tick("drain3", t, 1'b0);
        idle_tick("after drain3");

`ifdef CLKSCHED_STEP_EN
        // Step runs exactly one frame; start and stop are ignored meanwhile.
        bus.step = 1'b1;
        frame_tick("step", 0, 1'b0);
        bus.stop = 1'b1;
        frame_tick("step", 1, 1'b0);
        bus.start = 1'b1;
        for (int t = 2; t < FL; t++) frame_tick("step", t, 1'b0);
        idle_tick("after step a");
        idle_tick("after step b");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
